// File: rtl/pipe_stage_elastic_pkg.sv
// rtl/pipe_stage_elastic_pkg.sv - shared types and helpers for the elastic pipeline stage
package pipe_stage_elastic_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_FULL  = 2'd1,
      PS_SKID  = 2'd2
   } pipe_state_e;

   // Default bubble payload for stages whose NOP encoding is all zeros
   localparam logic [127:0] PS_NOP_ZERO = '0;

   function automatic logic [1:0] occupancy_of(pipe_state_e s);
      case (s)
         PS_FULL: return 2'd1;
         PS_SKID: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - upstream/downstream handshake bundle for the elastic stage
interface pipe_stage_elastic_if #(
   parameter int unsigned DATA_W = 128
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register with optional skid entry, flush and drop counter
module pipe_stage_elastic
   import pipe_stage_elastic_pkg::*;
#(
   parameter int unsigned       DATA_W    = 128,
   parameter logic [DATA_W-1:0] NOP_VALUE = '0,
   parameter bit                SKID      = 1'b1,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic               Clock,
   input  logic               nReset,
   pipe_stage_elastic_if.slave bus,
   input  logic               flush,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   drop_cnt
);

   pipe_state_e       state;
   pipe_state_e       state_nxt;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] skid_q;
   logic              in_ready_w;
   logic              out_valid_w;
   logic              in_fire;
   logic              out_fire;
   logic [1:0]        dropped;
   logic [CNT_W:0]    drop_sum;

   assign out_valid_w = (state != PS_EMPTY);
   assign in_fire     = bus.in_valid & in_ready_w;
   assign out_fire    = out_valid_w & bus.out_ready;
   assign occupancy   = occupancy_of(state);

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   // Bubble stages downstream decode the payload even when invalid
   assign bus.out_data  = out_valid_w ? main_q : NOP_VALUE;

   always_comb begin
      state_nxt = state;
      main_d    = main_q;
      case (state)
         PS_EMPTY: begin
            if (in_fire) begin
               state_nxt = PS_FULL;
               main_d    = bus.in_data;
            end
         end
         PS_FULL: begin
            if (in_fire && out_fire) begin
               main_d = bus.in_data;
            end else if (in_fire) begin
               state_nxt = SKID ? PS_SKID : PS_FULL;
            end else if (out_fire) begin
               state_nxt = PS_EMPTY;
               main_d    = NOP_VALUE;
            end
         end
         PS_SKID: begin
            if (out_fire) begin
               state_nxt = PS_FULL;
               main_d    = skid_q;
            end
         end
         default: begin
            state_nxt = PS_EMPTY;
            main_d    = NOP_VALUE;
         end
      endcase
      if (flush) begin
         state_nxt = PS_EMPTY;
         main_d    = NOP_VALUE;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state  <= PS_EMPTY;
         main_q <= NOP_VALUE;
      end else begin
         state  <= state_nxt;
         main_q <= main_d;
      end
   end

   generate
      if (SKID) begin : g_skid
         // Registered ready: a pure state decode keeps out_ready off the upstream timing path
         assign in_ready_w = (state != PS_SKID);

         always_ff @(posedge Clock or negedge nReset) begin
            if (!nReset) begin
               skid_q <= NOP_VALUE;
            end else if (flush) begin
               skid_q <= NOP_VALUE;
            end else if ((state == PS_FULL) && in_fire && !bus.out_ready) begin
               skid_q <= bus.in_data;
            end
         end
      end else begin : g_no_skid
         assign in_ready_w = (state == PS_EMPTY) | bus.out_ready;
         assign skid_q     = NOP_VALUE;
      end
   endgenerate

   // Entries leaving via out_fire in the flush cycle were delivered, not squashed
   assign dropped  = occupancy - {1'b0, out_fire};
   assign drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'(dropped);

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         drop_cnt <= '0;
      end else if (flush) begin
         drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic in three configurations
module tb_pipe_stage_elastic;

   localparam int unsigned DW  = 16;
   localparam logic [15:0] NOP = 16'h00A5;
   localparam logic [15:0] VA  = 16'h1111;
   localparam logic [15:0] VB  = 16'h2222;
   localparam logic [15:0] VC  = 16'h3333;
   localparam logic [15:0] VD  = 16'h4444;

   logic        Clock;
   logic        nReset;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_ready;
   logic        flush;

   logic [1:0]  occ_a, occ_b, occ_c;
   logic [15:0] drop_a, drop_c;
   logic [1:0]  drop_b;

   pipe_stage_elastic_if #(.DATA_W(DW)) if_a ();
   pipe_stage_elastic_if #(.DATA_W(DW)) if_b ();
   pipe_stage_elastic_if #(.DATA_W(DW)) if_c ();

   assign if_a.in_valid = in_valid;  assign if_a.in_data = in_data;  assign if_a.out_ready = out_ready;
   assign if_b.in_valid = in_valid;  assign if_b.in_data = in_data;  assign if_b.out_ready = out_ready;
   assign if_c.in_valid = in_valid;  assign if_c.in_data = in_data;  assign if_c.out_ready = out_ready;

   pipe_stage_elastic #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(16)) dut_a (
      .Clock(Clock), .nReset(nReset), .bus(if_a), .flush(flush), .occupancy(occ_a), .drop_cnt(drop_a));
   pipe_stage_elastic #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(2)) dut_b (
      .Clock(Clock), .nReset(nReset), .bus(if_b), .flush(flush), .occupancy(occ_b), .drop_cnt(drop_b));
   pipe_stage_elastic #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(1'b0), .CNT_W(16)) dut_c (
      .Clock(Clock), .nReset(nReset), .bus(if_c), .flush(flush), .occupancy(occ_c), .drop_cnt(drop_c));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: each stage is a bounded FIFO of held payloads plus a saturating counter
   logic [15:0] m_held [3][2];
   int          m_n    [3];
   int          m_cnt  [3];
   int          m_max  [3];
   bit          m_skid [3];
   string       m_name [3];

   typedef struct {
      bit          iv;
      logic [15:0] d;
      bit          orr;
      bit          fl;
      bit          e_ov;
      logic [15:0] e_od;
      bit          e_ir;
      int          e_occ;
      int          e_drop;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(bit iv, logic [15:0] d, bit orr, bit fl,
                               bit ov, logic [15:0] od, bit ir, int occ, int drp);
      vec_t v;
      v.iv = iv; v.d = d; v.orr = orr; v.fl = fl;
      v.e_ov = ov; v.e_od = od; v.e_ir = ir; v.e_occ = occ; v.e_drop = drp;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sample(input int d, output int ov, output int od, output int ir,
                         output int occ, output int drp);
      case (d)
         0: begin ov = int'(if_a.out_valid); od = int'(if_a.out_data); ir = int'(if_a.in_ready);
                  occ = int'(occ_a); drp = int'(drop_a); end
         1: begin ov = int'(if_b.out_valid); od = int'(if_b.out_data); ir = int'(if_b.in_ready);
                  occ = int'(occ_b); drp = int'(drop_b); end
         default: begin ov = int'(if_c.out_valid); od = int'(if_c.out_data); ir = int'(if_c.in_ready);
                  occ = int'(occ_c); drp = int'(drop_c); end
      endcase
   endtask

   function automatic bit exp_ready(int d);
      if (m_skid[d]) return m_n[d] < 2;
      return (m_n[d] == 0) || out_ready;
   endfunction

   task automatic check_all();
      int ov, od, ir, occ, drp;
      for (int d = 0; d < 3; d++) begin
         sample(d, ov, od, ir, occ, drp);
         chk({m_name[d], " out_valid"}, ov, int'(m_n[d] > 0));
         chk({m_name[d], " out_data"},  od, (m_n[d] > 0) ? int'(m_held[d][0]) : int'(NOP));
         chk({m_name[d], " in_ready"},  ir, int'(exp_ready(d)));
         chk({m_name[d], " occupancy"}, occ, m_n[d]);
         chk({m_name[d], " drop_cnt"},  drp, m_cnt[d]);
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 3; d++) begin
         bit inf, of;
         inf = in_valid && exp_ready(d);
         of  = (m_n[d] > 0) && out_ready;
         if (flush) begin
            m_cnt[d] = (m_cnt[d] + m_n[d] - int'(of) > m_max[d]) ? m_max[d]
                                                                  : m_cnt[d] + m_n[d] - int'(of);
            m_n[d] = 0;
         end else begin
            if (of) begin
               m_held[d][0] = m_held[d][1];
               m_n[d]--;
            end
            if (inf) begin
               m_held[d][m_n[d]] = in_data;
               m_n[d]++;
            end
         end
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_n[d]   = 0;
         m_cnt[d] = 0;
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge
   task automatic cycle(input bit iv, input logic [15:0] dat, input bit orr, input bit fl);
      in_valid = iv; in_data = dat; out_ready = orr; flush = fl;
      #1;
      check_all();
      model_step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic do_reset();
      #1 nReset = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst a out_valid", int'(if_a.out_valid), 0);
      chk("rst a out_data",  int'(if_a.out_data), int'(NOP));
      chk("rst a occupancy", int'(occ_a), 0);
      chk("rst a in_ready",  int'(if_a.in_ready), 1);
      chk("rst c in_ready",  int'(if_c.in_ready), 1);
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      @(posedge Clock);
      @(negedge Clock);
      nReset = 1'b1;
   endtask

   initial begin
      m_max[0] = 65535; m_max[1] = 3;  m_max[2] = 65535;
      m_skid[0] = 1'b1; m_skid[1] = 1'b1; m_skid[2] = 1'b0;
      m_name[0] = "a"; m_name[1] = "b"; m_name[2] = "c";
      model_reset();
      nReset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

      tbl[0]  = mk(1, VA, 1, 0,  0, NOP, 1, 0, 0);
      tbl[1]  = mk(1, VB, 1, 0,  1, VA,  1, 1, 0);
      tbl[2]  = mk(1, VC, 1, 0,  1, VB,  1, 1, 0);
      tbl[3]  = mk(0, VD, 1, 0,  1, VC,  1, 1, 0);
      tbl[4]  = mk(0, VD, 1, 0,  0, NOP, 1, 0, 0);
      tbl[5]  = mk(1, VA, 0, 0,  0, NOP, 1, 0, 0);
      tbl[6]  = mk(1, VB, 0, 0,  1, VA,  1, 1, 0);
      tbl[7]  = mk(1, VC, 0, 0,  1, VA,  0, 2, 0);
      tbl[8]  = mk(1, VC, 1, 0,  1, VA,  0, 2, 0);
      tbl[9]  = mk(1, VC, 1, 0,  1, VB,  1, 1, 0);
      tbl[10] = mk(0, VD, 1, 0,  1, VC,  1, 1, 0);
      tbl[11] = mk(0, VD, 1, 0,  0, NOP, 1, 0, 0);
      tbl[12] = mk(1, VA, 0, 0,  0, NOP, 1, 0, 0);
      tbl[13] = mk(1, VB, 0, 0,  1, VA,  1, 1, 0);
      tbl[14] = mk(1, VC, 0, 1,  1, VA,  0, 2, 0);
      tbl[15] = mk(1, VD, 1, 1,  0, NOP, 1, 0, 2);
      tbl[16] = mk(0, VD, 1, 0,  0, NOP, 1, 0, 2);
      tbl[17] = mk(1, VA, 0, 0,  0, NOP, 1, 0, 2);
      tbl[18] = mk(1, VB, 0, 0,  1, VA,  1, 1, 2);
      tbl[19] = mk(0, VD, 1, 1,  1, VA,  0, 2, 2);
      tbl[20] = mk(0, VD, 0, 0,  0, NOP, 1, 0, 3);

      @(negedge Clock);
      @(negedge Clock);
      check_all();
      nReset = 1'b1;

      // Reset while holding two entries
      cycle(1, VA, 0, 0);
      cycle(1, VB, 0, 0);
      chk("pre-reset a occupancy", int'(occ_a), 2);
      do_reset();

      for (int i = 0; i < 21; i++) begin
         in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].orr; flush = tbl[i].fl;
         #1;
         chk($sformatf("vec%0d out_valid", i), int'(if_a.out_valid), int'(tbl[i].e_ov));
         chk($sformatf("vec%0d out_data", i),  int'(if_a.out_data),  int'(tbl[i].e_od));
         chk($sformatf("vec%0d in_ready", i),  int'(if_a.in_ready),  int'(tbl[i].e_ir));
         chk($sformatf("vec%0d occupancy", i), int'(occ_a), tbl[i].e_occ);
         chk($sformatf("vec%0d drop_cnt", i),  int'(drop_a), tbl[i].e_drop);
         check_all();
         model_step();
         @(posedge Clock);
         @(negedge Clock);
      end

      // Saturation of the narrow counter: 2 held entries squashed per flush
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cycle(1, VA, 0, 0);
         cycle(1, VB, 0, 0);
         cycle(0, VD, 0, 1);
         chk($sformatf("sat%0d drop_b", k), int'(drop_b), (k == 0) ? 2 : 3);
         chk($sformatf("sat%0d drop_c", k), int'(drop_c), k + 1);
      end
      cycle(0, VD, 0, 1);
      chk("sat empty flush drop_b", int'(drop_b), 3);

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 3) != 0,
               $urandom_range(0, 19) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
